// File: rtl/i2s_pkg.sv
// Shared constants, state encoding and helpers for the I2S target port.
package i2s_pkg;

  // Serial slot geometry: data is left-justified in a 24-bit field of a 32-bit slot.
  localparam int SerialDataWidth = 24;
  localparam int SlotWidth       = 32;

  // Highest value the in-slot bit index can reach (saturates here).
  localparam logic [4:0] KMax = 5'(SlotWidth - 1);

  // Word-select encoding.
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [1:0] {
    UNSYNC_S = 2'd0,
    SHIFT_S  = 2'd1,
    TAIL_S   = 2'd2
  } i2s_target_state_e;

  // Increment the bit index, holding at KMax for slots longer than 32 bits.
  function automatic logic [4:0] k_sat_inc(input logic [4:0] k);
    logic [4:0] r;
    if (k == KMax) begin
      r = KMax;
    end else begin
      r = k + 5'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_input_sync.sv
// Multi-flop synchronizer for one asynchronous input, with edge detection
// on the synchronized value.
module i2s_input_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SyncStages-1:0] sync_q;
  logic [SyncStages-1:0] sync_d;
  logic                  prev_q;
  logic                  prev_d;

  // Next state of the synchronizer chain and the one-cycle-delayed copy.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], din};
    prev_d = sync_q[SyncStages-1];
  end

  // Synchronizer and edge-history flops.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[SyncStages-1];
  assign rise = sync_q[SyncStages-1] & ~prev_q;
  assign fall = ~sync_q[SyncStages-1] & prev_q;

endmodule

// File: rtl/i2s_target_port.sv
// I2S target port: follows an external SCLK/LRCK, deserializes SDIN into
// DataWidth-bit samples and serializes the held transmit sample onto SDOUT.
module i2s_target_port
  import i2s_pkg::*;
#(
  parameter int DataWidth  = 12,
  parameter int SyncStages = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 sclk,
  input  logic                 lrck,
  input  logic                 sdin,
  output logic                 sdout,
  output logic [DataWidth-1:0] rxData,
  output logic                 rxChannel,
  output logic                 rxDataValid,
  input  logic [DataWidth-1:0] txData,
  input  logic                 txDataValid,
  output logic                 frameError
);

  localparam logic [4:0] DataK = 5'(DataWidth);
  localparam logic [4:0] LastK = (DataWidth > SerialDataWidth) ? 5'(DataWidth)
                                                               : 5'(SerialDataWidth);
  localparam logic [4:0] TxMsb = 5'(SerialDataWidth - 1);
  localparam int         PadBits = SerialDataWidth - DataWidth;

  // Synchronized inputs.
  logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
  logic lrck_sync_s, sdin_sync_s;
  logic unused_lrck_rise_s, unused_lrck_fall_s;
  logic unused_sdin_rise_s, unused_sdin_fall_s;

  // Slot tracking.
  i2s_target_state_e state_q, state_d;
  logic [4:0] k_q, k_d;
  logic       lrck_q, lrck_d;
  logic       seen_q, seen_d;
  logic       cur_chan_q, cur_chan_d;
  logic       slot_start_s;
  logic       rx_shift_s;
  logic       rx_last_s;

  // Receive path.
  logic [DataWidth-1:0] shift_rx_q, shift_rx_d;
  logic                 rx_pend_q, rx_pend_d;
  logic [DataWidth-1:0] rx_data_q, rx_data_d;
  logic                 rx_chan_q, rx_chan_d;
  logic                 rx_valid_q, rx_valid_d;

  // Transmit path.
  logic [DataWidth-1:0]       tx_hold_q, tx_hold_d;
  logic [SerialDataWidth-1:0] shift_tx_q, shift_tx_d;
  logic                       sdout_q, sdout_d;

  logic frame_err_q, frame_err_d;

  i2s_input_sync #(.SyncStages(SyncStages)) u_sync_sclk (
    .clk   (clk),
    .resetN(resetN),
    .din   (sclk),
    .dout  (sclk_sync_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  i2s_input_sync #(.SyncStages(SyncStages)) u_sync_lrck (
    .clk   (clk),
    .resetN(resetN),
    .din   (lrck),
    .dout  (lrck_sync_s),
    .rise  (unused_lrck_rise_s),
    .fall  (unused_lrck_fall_s)
  );

  i2s_input_sync #(.SyncStages(SyncStages)) u_sync_sdin (
    .clk   (clk),
    .resetN(resetN),
    .din   (sdin),
    .dout  (sdin_sync_s),
    .rise  (unused_sdin_rise_s),
    .fall  (unused_sdin_fall_s)
  );

  logic unused_sclk_level_s;
  assign unused_sclk_level_s = sclk_sync_s;

  // Slot tracking: word-select change detection, bit index and sync FSM.
  // A word-select change is only trusted once one SCLK rise has been seen
  // since reset, so a reset in the middle of a slot never yields a partial word.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    lrck_d       = lrck_q;
    seen_d       = seen_q;
    cur_chan_d   = cur_chan_q;
    frame_err_d  = 1'b0;
    slot_start_s = 1'b0;
    rx_shift_s   = 1'b0;
    rx_last_s    = 1'b0;
    if (sclk_rise_s) begin
      lrck_d = lrck_sync_s;
      seen_d = 1'b1;
      if (seen_q && (lrck_sync_s != lrck_q)) begin
        slot_start_s = 1'b1;
        k_d          = 5'd0;
        cur_chan_d   = lrck_sync_s;
        state_d      = SHIFT_S;
        if ((state_q != UNSYNC_S) && (k_q != KMax)) begin
          frame_err_d = 1'b1;
        end else begin
          frame_err_d = 1'b0;
        end
      end else begin
        k_d = k_sat_inc(k_q);
        case (state_q)
          SHIFT_S: begin
            if ((k_d >= 5'd1) && (k_d <= DataK)) begin
              rx_shift_s = 1'b1;
              rx_last_s  = (k_d == DataK);
            end else begin
              rx_shift_s = 1'b0;
              rx_last_s  = 1'b0;
            end
            if (k_d > LastK) begin
              state_d = TAIL_S;
            end else begin
              state_d = SHIFT_S;
            end
          end
          UNSYNC_S: state_d = UNSYNC_S;
          TAIL_S:   state_d = TAIL_S;
          default:  state_d = UNSYNC_S;
        endcase
      end
    end else begin
      state_d = state_q;
      k_d     = k_q;
    end
  end

  // Receive: MSB-first shift for bits 1..DataWidth, publish one clk later.
  always_comb begin
    shift_rx_d = shift_rx_q;
    rx_pend_d  = rx_last_s;
    rx_valid_d = rx_pend_q;
    rx_chan_d  = rx_chan_q;
    rx_data_d  = rx_data_q;
    if (rx_shift_s) begin
      shift_rx_d = {shift_rx_q[DataWidth-2:0], sdin_sync_s};
    end else begin
      shift_rx_d = shift_rx_q;
    end
    if (rx_pend_q) begin
      rx_data_d = shift_rx_q;
      rx_chan_d = cur_chan_q;
    end else begin
      rx_data_d = rx_data_q;
      rx_chan_d = rx_chan_q;
    end
  end

  // Transmit: hold register, per-slot snapshot at k=0, bit driven on SCLK fall.
  always_comb begin
    tx_hold_d  = tx_hold_q;
    shift_tx_d = shift_tx_q;
    sdout_d    = sdout_q;
    if (txDataValid) begin
      tx_hold_d = txData;
    end else begin
      tx_hold_d = tx_hold_q;
    end
    if (slot_start_s) begin
      shift_tx_d = SerialDataWidth'(tx_hold_q) << PadBits;
    end else begin
      shift_tx_d = shift_tx_q;
    end
    if (sclk_fall_s) begin
      if ((state_q == SHIFT_S) && (k_q <= TxMsb)) begin
        sdout_d = shift_tx_q[TxMsb - k_q];
      end else begin
        sdout_d = 1'b0;
      end
    end else begin
      sdout_d = sdout_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= UNSYNC_S;
      k_q         <= 5'd0;
      lrck_q      <= LEFT;
      seen_q      <= 1'b0;
      cur_chan_q  <= LEFT;
      shift_rx_q  <= '0;
      rx_pend_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_chan_q   <= LEFT;
      rx_valid_q  <= 1'b0;
      tx_hold_q   <= '0;
      shift_tx_q  <= '0;
      sdout_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      lrck_q      <= lrck_d;
      seen_q      <= seen_d;
      cur_chan_q  <= cur_chan_d;
      shift_rx_q  <= shift_rx_d;
      rx_pend_q   <= rx_pend_d;
      rx_data_q   <= rx_data_d;
      rx_chan_q   <= rx_chan_d;
      rx_valid_q  <= rx_valid_d;
      tx_hold_q   <= tx_hold_d;
      shift_tx_q  <= shift_tx_d;
      sdout_q     <= sdout_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sdout       = sdout_q;
  assign rxData      = rx_data_q;
  assign rxChannel   = rx_chan_q;
  assign rxDataValid = rx_valid_q;
  assign frameError  = frame_err_q;

endmodule

// File: tb/tb_i2s_target_port.sv
// Bench for i2s_target_port: an I2S master model drives SCLK (8 clk/bit),
// LRCK and SDIN, captures SDOUT on SCLK rises, and a scoreboard checks rx words.
module tb_i2s_target_port;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          sclk = 1'b0;
  logic          lrck = 1'b1;
  logic          sdin = 1'b0;
  logic [DW-1:0] txData = '0;
  logic          txDataValid = 1'b0;
  logic          sdout;
  logic [DW-1:0] rxData;
  logic          rxChannel;
  logic          rxDataValid;
  logic          frameError;

  i2s_target_port #(.DataWidth(DW), .SyncStages(2)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .sclk       (sclk),
    .lrck       (lrck),
    .sdin       (sdin),
    .sdout      (sdout),
    .rxData     (rxData),
    .rxChannel  (rxChannel),
    .rxDataValid(rxDataValid),
    .txData     (txData),
    .txDataValid(txDataValid),
    .frameError (frameError)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW:0]   rx_q[$];       // expected {channel, sample}
  int            ferr_seen = 0;
  int            exp_ferr  = 0;
  bit            synced    = 1'b0;
  bit            seen      = 1'b0;
  int            prev_len  = 32;
  logic [DW-1:0] model_hold = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every rx pulse, count frame-error pulses.
  always @(negedge clk) begin
    if (rxDataValid) begin
      if (rx_q.size() == 0) begin
        chk("rx_unexpected_pulse", rx_q.size(), 1);
      end else begin
        chk("rx_word", {rxChannel, rxData}, rx_q.pop_front());
      end
    end
    if (frameError) ferr_seen++;
  end

  // One slot from the master: lrck set on the first fall, data MSB on the
  // second fall, SDOUT sampled on every rise. Optional tx load / reset at bit j.
  task automatic send_slot(input bit chan, input logic [23:0] word, input int len,
                           input int load_at, input logic [DW-1:0] load_val,
                           input int rst_at);
    logic [31:0] cap;
    logic [31:0] expv;
    logic [31:0] mask;
    logic [23:0] exp_tx;
    bit          changed;
    bit          active;
    changed = (chan != lrck);
    if (changed && synced && prev_len < 32) exp_ferr++;
    if (changed && seen) synced = 1'b1;
    seen   = 1'b1;
    active = synced;
    exp_tx = 24'(model_hold) << (24 - DW);
    if (synced && len > DW && rst_at < 0) rx_q.push_back({chan, word[23 -: DW]});
    cap = '0;
    for (int j = 0; j < len; j++) begin
      sclk = 1'b0;
      if (j == 0) lrck = chan;
      sdin = (j >= 1 && j <= 24) ? word[24 - j] : 1'b0;
      if (j == load_at) begin
        txData = load_val;
        txDataValid = 1'b1;
      end
      if (j == rst_at) begin
        resetN = 1'b0;
        #1;
        chk("reset_mid_word_outputs", {sdout, rxChannel, rxDataValid, frameError, rxData}, 32'h0);
        synced = 1'b0;
        model_hold = '0;
      end
      @(negedge clk);
      txDataValid = 1'b0;
      resetN = 1'b1;
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      if (j >= 1 && j < 32) cap[j] = sdout;
      repeat (4) @(negedge clk);
    end
    prev_len = len;
    if (load_at >= 0) model_hold = load_val;
    expv = '0;
    mask = '0;
    for (int r = 1; r < len && r < 32; r++) begin
      mask[r] = 1'b1;
      if (active && r <= 24) expv[r] = exp_tx[24 - r];
    end
    if (rst_at < 0) chk("tx_serial", cap & mask, expv);
    chk("rx_missing", rx_q.size(), 0);
  endtask

  task automatic load_tx(input logic [DW-1:0] v);
    txData = v;
    txDataValid = 1'b1;
    @(negedge clk);
    txDataValid = 1'b0;
    model_hold = v;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_outputs", {sdout, rxChannel, rxDataValid, frameError, rxData}, 32'h0);
    resetN = 1'b1;
    repeat (4) @(negedge clk);

    // Stray half-frame: no word select change yet, nothing should come out.
    send_slot(1'b1, 24'($urandom), 32, -1, '0, -1);

    // Directed frame with a preloaded transmit sample.
    load_tx(12'h5A3);
    send_slot(1'b0, 24'hABC123, 32, -1, '0, -1);
    send_slot(1'b1, 24'h800000, 32, -1, '0, -1);

    // Load mid-left-slot: left keeps the old word, right gets the new one.
    send_slot(1'b0, 24'($urandom), 32, 10, 12'h111, -1);
    send_slot(1'b1, 24'($urandom), 32, -1, '0, -1);

    // Random frames with occasional mid-slot loads.
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 2; c++) begin
        int la;
        la = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 28)) : -1;
        send_slot(c[0], 24'($urandom), 32, la, DW'($urandom), -1);
      end
    end

    // Shortened slot: one frame error, then clean slots.
    send_slot(1'b0, 24'($urandom), 20, -1, '0, -1);
    send_slot(1'b1, 24'($urandom), 32, -1, '0, -1);
    chk("frame_err_after_short", ferr_seen, exp_ferr);
    send_slot(1'b0, 24'($urandom), 32, -1, '0, -1);
    send_slot(1'b1, 24'($urandom), 32, -1, '0, -1);

    // Reset in the middle of a left word, then resync on the next change.
    load_tx(12'h9C7);
    send_slot(1'b0, 24'($urandom), 32, -1, '0, 8);
    send_slot(1'b1, 24'($urandom), 32, -1, '0, -1);
    load_tx(DW'($urandom));
    send_slot(1'b0, 24'($urandom), 32, -1, '0, -1);
    send_slot(1'b1, 24'($urandom), 32, -1, '0, -1);

    repeat (16) @(negedge clk);
    chk("frame_err_total", ferr_seen, exp_ferr);
    chk("rx_queue_empty", rx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_target_port.md
Name: i2s_target_port

Overview:
I2S target (slave) port. It receives externally generated SCLK/LRCK and runs the codec side of the link. It deserializes the serial-data input into DataWidth-bit samples and serializes a DataWidth-bit sample, left-justified into a 24-bit slot, onto the serial-data output. It is used as a loopback/codec model opposite the I2S master controller, and as the front end when the chip is clocked by an external I2S master.

Parameters:
DataWidth, 12, sample width on the parallel ports (must be 2..24)
SyncStages, 2, synchronizer flops on sclk, lrck and sdin (≥2)

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous active-low reset
sclk  input  1  external bit clock, asynchronous to clk
lrck  input  1  external word select: 0 = left, 1 = right
sdin  input  1  serial data from the master
sdout  output  1  serial data to the master
rxData  output  DataWidth  last received sample (signed)
rxChannel  output  1  channel of rxData
rxDataValid  output  1  one-clk pulse, rxData/rxChannel are new
txData  input  DataWidth  sample to transmit (signed, same value on both channels)
txDataValid  input  1  load txData into the holding register
frameError  output  1  one-clk pulse on a malformed channel slot

Behaviour:
- Clocking/reset: one clock domain, clk. resetN is asynchronous and active-low.
- Reset values: all outputs 0, synchronizers 0, state UNSYNC, txHold 0.
- Synchronization:
  - sclk, lrck and sdin each pass through SyncStages flops.
  - sclkRise/sclkFall = synchronized sclk compared against its previous value.
  - Constraint: sclk high and low phases each ≥ SyncStages+2 clk.
- Bit index k (5-bit) counts sclk rising edges within a channel slot.
  - At each sclkRise, the synchronized lrck is sampled. If it differs from the stored lrck, this rise is k=0 (I2S one-bit delay slot) and curChan = new lrck.
  - Otherwise k increments, saturating at 31.
- States:
  - UNSYNC: sdout=0, no rx output. Leaves on the first detected lrck change, entering SHIFT at k=0. Guarantees no partial first word.
  - SHIFT: active for k=0..max(DataWidth,24). Receive and transmit as below.
  - TAIL: k > 24 and k > DataWidth. sdout=0. Waits for the next lrck change, which re-enters SHIFT at k=0.
- Receive:
  - At sclkRise with k=1..DataWidth, shiftRx <= {shiftRx[DataWidth-2:0], sdinSync}. MSB first.
  - Bits k > DataWidth are ignored, which truncates 24-bit input.
  - On the clk after the k=DataWidth capture: rxData <= shiftRx, rxChannel <= curChan, rxDataValid=1 for exactly one clk.
- Transmit:
  - txDataValid loads txHold any cycle.
  - At the k=0 rise, shiftTx(24 bits) <= {txHold, (24-DataWidth) zeros}. A txDataValid mid-slot never tears the current word.
  - At each sclkFall following rise k (k=0..23), sdout <= shiftTx bit (23-k). MSB is therefore driven on the fall after the delay slot.
  - For k ≥ 24, sdout=0.
  - sdout updates within SyncStages+1 clk of the sclk falling edge.
- Frame error:
  - On an lrck change in SHIFT/TAIL where the previous slot's final k ≠ 31 (slot length ≠ 32), pulse frameError for one clk.
  - The port still resynchronizes to the new slot at k=0. No rxDataValid is emitted for a truncated slot that had not yet reached k=DataWidth.
- Simultaneous events: an lrck change and a txDataValid in the same clk → the new txData is not used for this slot (the load precedes the next k=0 capture only if it arrives earlier).
- Reset mid-word: everything clears and the block returns to UNSYNC; sdout=0 until the next lrck change.
- sclk stopped: state holds indefinitely, no timeout.

Decomposition:
- Package i2s_pkg:
  - SerialDataWidth=24, SlotWidth=32.
  - Typedef i2s_target_state_e {UNSYNC_S, SHIFT_S, TAIL_S}.
  - Channel constants LEFT=0, RIGHT=1.
- Sub-module i2s_input_sync: parameterized SyncStages-deep synchronizer plus rise/fall detectors. Instantiated for sclk (with edges), lrck and sdin.

Test Plan:
- Bench setup: bench master with clk=8×sclk, 64 sclk/frame; DataWidth=12.
- Reset, one stray half-frame, then full frames → no rxDataValid and sdout=0 until the first lrck change; the first valid pulse arrives in the following slot.
- Master sends left 24'hABC123, right 24'h800000 → rxData 12'hABC (rxChannel 0), then 12'h800 (rxChannel 1); exactly two pulses per frame.
- txData=12'h5A3 with txDataValid before the frame → on both channels, captured serial = 24'h5A3000, MSB at the second sclk rise after lrck change; bits 24..31 are 0.
- txDataValid with 12'h111 at k=10 of the left slot → left word still carries the old value; right slot carries 24'h111000.
- Master shortens one slot to 20 sclk → frameError pulses once; the next 32-bit slot is received correctly with no further errors.
- Assert resetN low at k=8 mid-word → all outputs 0 immediately (async); after release, no rxDataValid before the next lrck change.
